// File: rtl/wb_spi_bridge_if.sv
// Signal bundle for the Wishbone-to-SPI-core bridge: the upstream (s_*) and downstream (m_*) buses.
// The slave modport is the bridge's view. The master modport is the surrounding system's view.
interface wb_spi_bridge_if;
  // upstream Wishbone, driven by the I2C-to-Wishbone master
  logic       s_cyc_i;
  logic       s_stb_i;
  logic       s_we_i;
  logic [7:0] s_adr_i;
  logic [3:0] s_sel_i;
  logic [7:0] s_dat_i;
  logic [7:0] s_dat_o;
  logic       s_ack_o;
  logic       s_err_o;
  logic       s_rty_o;

  // downstream Wishbone to the SPI core
  logic       m_cyc_o;
  logic       m_stb_o;
  logic       m_we_o;
  logic [1:0] m_adr_o;
  logic [7:0] m_dat_o;
  logic [7:0] m_dat_i;
  logic       m_ack_i;

  modport slave (
    input  s_cyc_i, s_stb_i, s_we_i, s_adr_i, s_sel_i, s_dat_i, m_dat_i, m_ack_i,
    output s_dat_o, s_ack_o, s_err_o, s_rty_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o
  );

  modport master (
    output s_cyc_i, s_stb_i, s_we_i, s_adr_i, s_sel_i, s_dat_i, m_dat_i, m_ack_i,
    input  s_dat_o, s_ack_o, s_err_o, s_rty_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o
  );
endinterface

// File: rtl/wb_spi_bridge.sv
// Forwards upstream Wishbone accesses to a 4-register SPI core window, with a downstream ack timeout.
// All outputs are registered. Address misses and timeouts terminate upstream with an error.
module wb_spi_bridge #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter logic [7:0] TIMEOUT   = 8'd255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_spi_bridge_if.slave     bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FWD  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic [7:0] cnt;
  logic       aborted;
  logic       req;
  logic       hit;
  logic       fwd_done;
  logic       upstream_gone;
  logic       unused_sel;

  assign req           = bus.s_cyc_i & bus.s_stb_i;
  assign hit           = (bus.s_adr_i[7:2] == BASE_ADDR[7:2]) & bus.s_sel_i[0];
  // an ack in the timeout cycle still counts as a normal completion
  assign fwd_done      = bus.m_ack_i | (cnt == TIMEOUT);
  assign upstream_gone = aborted | ~bus.s_cyc_i;
  assign unused_sel    = ^bus.s_sel_i[3:1];

  assign bus.s_rty_o = 1'b0;

  // NOTE: every register here is assigned with <= so all updates take effect together at the clock edge.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      aborted     <= 1'b0;
      bus.s_dat_o <= 8'h00;
      bus.s_ack_o <= 1'b0;
      bus.s_err_o <= 1'b0;
      bus.m_cyc_o <= 1'b0;
      bus.m_stb_o <= 1'b0;
      bus.m_we_o  <= 1'b0;
      bus.m_adr_o <= 2'b00;
      bus.m_dat_o <= 8'h00;
    end else begin
      // terminations are single-cycle pulses unless re-asserted below
      bus.s_ack_o <= 1'b0;
      bus.s_err_o <= 1'b0;

      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              bus.m_cyc_o <= 1'b1;
              bus.m_stb_o <= 1'b1;
              bus.m_we_o  <= bus.s_we_i;
              bus.m_adr_o <= bus.s_adr_i[1:0];
              bus.m_dat_o <= bus.s_dat_i;
              cnt         <= 8'd0;
              aborted     <= 1'b0;
              state       <= FWD;
            end else begin
              bus.s_err_o <= 1'b1;
              state       <= RESP;
            end
          end
        end

        FWD: begin
          if (fwd_done) begin
            bus.m_cyc_o <= 1'b0;
            bus.m_stb_o <= 1'b0;
            if (upstream_gone) begin
              // upstream abandoned the cycle: finish quietly, nothing to answer
              state <= IDLE;
            end else begin
              if (bus.m_ack_i) begin
                bus.s_ack_o <= 1'b1;
                if (!bus.m_we_o) bus.s_dat_o <= bus.m_dat_i;
              end else begin
                bus.s_err_o <= 1'b1;
              end
              state <= RESP;
            end
          end else begin
            cnt <= cnt + 8'd1;
            if (!bus.s_cyc_i) aborted <= 1'b1;
          end
        end

        RESP: begin
          // wait for the strobe to drop so one strobe never yields two downstream cycles
          if (!bus.s_stb_i) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
